// File: rtl/filter_frame_ctrl.sv
// Frame controller around an external pixel filter: selects filtered, bypass or blanked video, applies config at frame start.
// Latency: post_* follows pre_* by FILT_LAT+1 cycles in every mode; status flags register one cycle after the triggering edge.
// Backpressure: none; streaming video timing, one pixel per cycle, the source cannot be stalled.
module filter_frame_ctrl #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          FILT_LAT     = 4,
  parameter int          H_DISP       = 1280,
  parameter int          V_DISP       = 720,
  parameter logic [1:0]  DEFAULT_MODE = 2'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pre_img_vsync,
  input  logic                  pre_img_hsync,
  input  logic                  pre_img_valid,
  input  logic [DATA_WIDTH-1:0] pre_img_data,
  output logic                  filt_in_vsync,
  output logic                  filt_in_hsync,
  output logic                  filt_in_valid,
  output logic [DATA_WIDTH-1:0] filt_in_data,
  input  logic                  filt_out_vsync,
  input  logic                  filt_out_hsync,
  input  logic                  filt_out_valid,
  input  logic [DATA_WIDTH-1:0] filt_out_data,
  output logic                  post_img_vsync,
  output logic                  post_img_hsync,
  output logic                  post_img_valid,
  output logic [DATA_WIDTH-1:0] post_img_data,
  input  logic                  cfg_wr,
  input  logic [1:0]            cfg_mode,
  output logic                  cfg_pending,
  output logic                  cfg_done,
  output logic [1:0]            cur_mode,
  output logic [15:0]           frame_cnt,
  output logic                  frame_err
);

  localparam int PIX_TOT = H_DISP * V_DISP;
  localparam int PCW     = $clog2(PIX_TOT + 1);
  localparam int DCW     = $clog2(FILT_LAT + 1);
  localparam logic [PCW-1:0] PIX_MAX = '1;
  localparam logic [PCW-1:0] PIX_EXP = PCW'(PIX_TOT);
  localparam logic [1:0] M_MEDIAN = 2'd1;
  localparam logic [1:0] M_BLANK  = 2'd2;

  typedef struct packed {
    logic                  vsync;
    logic                  hsync;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } pix_t;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            vsync_q, vsync_d;
  logic [1:0]      pend_mode_q, pend_mode_d;
  logic            cfg_pending_q, cfg_pending_d;
  logic            cfg_done_q, cfg_done_d;
  logic [1:0]      cur_mode_q, cur_mode_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            frame_err_q, frame_err_d;
  logic [PCW-1:0]  pix_cnt_q, pix_cnt_d;
  pix_t            dly_q [FILT_LAT];
  pix_t            dly_d [FILT_LAT];
  pix_t            post_q, post_d;

  pix_t            pre_pix, filt_pix, dly_out;
  logic            frame_start, frame_end, apply;
  logic [PCW-1:0]  pix_cnt_inc;

  assign pre_pix  = {pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data};
  assign filt_pix = {filt_out_vsync, filt_out_hsync, filt_out_valid, filt_out_data};
  assign dly_out  = dly_q[FILT_LAT-1];

  assign frame_start = pre_img_vsync & ~vsync_q;
  assign frame_end   = ~pre_img_vsync & vsync_q;
  // Count includes a pixel arriving in the frame-end cycle so the size check sees it.
  assign pix_cnt_inc = (pre_img_valid && pix_cnt_q != PIX_MAX) ? pix_cnt_q + PCW'(1) : pix_cnt_q;

  // Frame FSM, pixel accounting and config staging; config only lands at a frame start.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    vsync_d       = pre_img_vsync;
    pend_mode_d   = pend_mode_q;
    cfg_pending_d = cfg_pending_q;
    cfg_done_d    = 1'b0;
    cur_mode_d    = cur_mode_q;
    frame_cnt_d   = frame_cnt_q;
    frame_err_d   = 1'b0;
    pix_cnt_d     = pix_cnt_q;
    apply         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_ACTIVE;
          apply   = 1'b1;
        end
      end
      S_ACTIVE: begin
        pix_cnt_d = pix_cnt_inc;
        if (frame_end) begin
          state_d     = S_DRAIN;
          drain_d     = DCW'(FILT_LAT);
          frame_cnt_d = frame_cnt_q + 16'd1;
          frame_err_d = (pix_cnt_inc != PIX_EXP);
        end
      end
      S_DRAIN: begin
        if (frame_start) begin
          state_d = S_ACTIVE;
          apply   = 1'b1;
        end else if (drain_q == '0) begin
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (apply) begin
      pix_cnt_d = '0;
      if (cfg_pending_q) begin
        cur_mode_d    = pend_mode_q;
        cfg_done_d    = 1'b1;
        cfg_pending_d = 1'b0;
      end
    end
    // A write in the apply cycle stays pending; the value applied above is the older one.
    if (cfg_wr) begin
      pend_mode_d   = cfg_mode;
      cfg_pending_d = 1'b1;
    end
  end

  // Bypass delay line matched to the filter, then mode-selected output register.
  always_comb begin
    dly_d[0] = pre_pix;
    for (int i = 1; i < FILT_LAT; i++) dly_d[i] = dly_q[i-1];
    case (cur_mode_q)
      M_MEDIAN: post_d = filt_pix;
      M_BLANK: begin
        post_d      = dly_out;
        post_d.data = '0;
      end
      default:  post_d = dly_out;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      drain_q       <= '0;
      vsync_q       <= 1'b0;
      pend_mode_q   <= '0;
      cfg_pending_q <= 1'b0;
      cfg_done_q    <= 1'b0;
      cur_mode_q    <= DEFAULT_MODE;
      frame_cnt_q   <= '0;
      frame_err_q   <= 1'b0;
      pix_cnt_q     <= '0;
      dly_q         <= '{default: '0};
      post_q        <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      vsync_q       <= vsync_d;
      pend_mode_q   <= pend_mode_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_done_q    <= cfg_done_d;
      cur_mode_q    <= cur_mode_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_err_q   <= frame_err_d;
      pix_cnt_q     <= pix_cnt_d;
      dly_q         <= dly_d;
      post_q        <= post_d;
    end
  end

  assign filt_in_vsync  = pre_img_vsync;
  assign filt_in_hsync  = pre_img_hsync;
  assign filt_in_valid  = pre_img_valid;
  assign filt_in_data   = pre_img_data;
  assign post_img_vsync = post_q.vsync;
  assign post_img_hsync = post_q.hsync;
  assign post_img_valid = post_q.valid;
  assign post_img_data  = post_q.data;
  assign cfg_pending    = cfg_pending_q;
  assign cfg_done       = cfg_done_q;
  assign cur_mode       = cur_mode_q;
  assign frame_cnt      = frame_cnt_q;
  assign frame_err      = frame_err_q;

endmodule

// File: doc/filter_frame_ctrl.md
FILTER_FRAME_CTRL -- requirements
Module: filter_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter FILT_LAT, default 4, cycles from filt_in_* to filt_out_* of the attached filter.
REQ-003 SHALL have parameter H_DISP, default 1280, active pixels per line.
REQ-004 SHALL have parameter V_DISP, default 720, active lines per frame.
REQ-005 SHALL have parameter DEFAULT_MODE, default 2'd1, mode after reset.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports pre_img_vsync/hsync/valid  input  1 each  source timing; pre_img_data  input  DATA_WIDTH.
REQ-009 SHALL have ports filt_in_vsync/hsync/valid  output  1 each; filt_in_data  output  DATA_WIDTH  to filter (combinational pass-through of pre_*).
REQ-010 SHALL have ports filt_out_vsync/hsync/valid  input  1 each; filt_out_data  input  DATA_WIDTH  from filter.
REQ-011 SHALL have ports post_img_vsync/hsync/valid  output  1 each; post_img_data  output  DATA_WIDTH  selected stream.
REQ-012 SHALL have ports cfg_wr  input  1  config write strobe; cfg_mode  input  2  0=BYPASS, 1=MEDIAN, 2=BLANK, 3=reserved (treated as BYPASS).
REQ-013 SHALL have ports cfg_pending  output  1; cfg_done  output  1  one-cycle pulse on apply; cur_mode  output  2.
REQ-014 SHALL have ports frame_cnt  output  16  completed frames; frame_err  output  1  one-cycle pulse on bad pixel count.

Function
REQ-015 Frame start = rising edge of pre_img_vsync; frame end = falling edge.
REQ-016 FSM states: IDLE, ACTIVE, DRAIN.
REQ-017 IDLE -> ACTIVE on frame start; pending config applied in that same cycle (cur_mode updated, cfg_done=1, cfg_pending cleared).
REQ-018 ACTIVE -> DRAIN on frame end; DRAIN counter loads FILT_LAT.
REQ-019 DRAIN decrements per cycle; at 0 -> IDLE; frame start during DRAIN -> ACTIVE directly, applying pending config.
REQ-020 cfg_wr latches cfg_mode into pending register, sets cfg_pending; a later cfg_wr before apply overwrites it.
REQ-021 cfg_wr in the apply cycle: old pending value applied, new value stays pending for next frame.
REQ-022 cur_mode never changes in ACTIVE or DRAIN.
REQ-023 Bypass path: pre_* delayed FILT_LAT cycles in a shift register, independent of mode.
REQ-024 Output registered, total latency FILT_LAT+1 from pre_* in all modes.
REQ-025 MEDIAN: post_* = registered filt_out_*.
REQ-026 BYPASS/reserved: post_* = registered delayed pre_*.
REQ-027 BLANK: post sync/valid from delayed pre_*; post_img_data = 0.
REQ-028 pix_cnt (width ceil(log2(H_DISP*V_DISP+1))) clears on frame start, increments on pre_img_valid in ACTIVE, saturates at max.
REQ-029 On frame end: frame_cnt increments (wraps 16'hFFFF->0); frame_err pulses if pix_cnt != H_DISP*V_DISP.
REQ-030 pre_img_valid outside ACTIVE ignored by pix_cnt.

Reset
REQ-031 While rst_n=0: state IDLE, cur_mode=DEFAULT_MODE, pending cleared, cfg_pending=0, cfg_done=0, frame_cnt=0, pix_cnt=0, frame_err=0, delay lines and post_* = 0.
REQ-032 Reset mid-frame abandons the frame; first frame start after release is a normal frame start with no frame_err for the abandoned frame.

Verification (H_DISP=4, V_DISP=2, FILT_LAT=4)
REQ-033 Reset, one 8-pixel frame, no cfg -> cur_mode=1, post_* equal filt_out_* delayed 1 cycle, frame_cnt=1, no frame_err.
REQ-034 cfg_wr mode 0 mid-frame -> cfg_pending=1, output stays MEDIAN until next vsync rise; then cfg_done pulse, post_img_data = pre_img_data delayed 5 cycles.
REQ-035 Two cfg_wr (2 then 0) before frame start -> applied mode 0; cfg_wr mode 2 in apply cycle -> mode 2 applied on following frame.
REQ-036 Frame with 7 valid pixels -> frame_err pulse one cycle after vsync fall; frame_cnt still increments.
REQ-037 Mode 2 frame -> post_img_valid pattern matches input delayed 5, post_img_data all 0.
REQ-038 rst_n low mid-frame, release, full frame -> frame_cnt=1, no frame_err, cur_mode=1; frame_cnt preset near 16'hFFFF wraps to 0.
